o_writeback: RTL
================

Name: o_writeback

Overview:
- Sits directly downstream of the PE backend.
- Consumes the scaled output vector `output_vector_scaled` under the PE's `output_valid` / `O_sram_rdy` handshake.
- Buffers up to two vectors, serializes each into ELEMS_PER_WORD-wide OSRAM write beats at consecutive addresses, and signals completion after NUM_ROWS vectors.
- Decouples PE throughput from OSRAM write-port availability.

Parameters:
EMB_DIM, `MAX_EMBEDDING_DIM (64), elements per output vector
ELEM_W, 16, bits per output element (O_VECTOR_T element width)
ELEMS_PER_WORD, 8, elements per OSRAM word; EMB_DIM must be a multiple
NUM_ROWS, 128, vectors per tile before done
ADDR_W, 12, OSRAM address width
WPV (localparam), EMB_DIM/ELEMS_PER_WORD, beats per vector

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; latch base_addr_in, begin tile
base_addr_in  in  ADDR_W  tile base address
vld_in  in  1  upstream valid (PE output_valid)
rdy_out  out  1  ready to upstream (drives PE O_sram_rdy)
o_vec_in  in  EMB_DIM*ELEM_W  element i at bits [i*ELEM_W +: ELEM_W]
sram_we  out  1  write request
sram_rdy  in  1  OSRAM accepts write this cycle
sram_addr  out  ADDR_W  write address
sram_wdata  out  ELEMS_PER_WORD*ELEM_W  write data
busy  out  1  tile in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst low, async): state IDLE; FIFO empty; all counters 0; rdy_out=0, sram_we=0, sram_addr=0, sram_wdata=0, busy=0, done=0. Reset mid-tile abandons all pending beats.
- FSM:
  - IDLE: start → RUN; clear row_in, row_out, beat counters; latch base.
  - RUN → DONE on the cycle the final beat of row NUM_ROWS-1 is accepted (sram_we && sram_rdy).
  - DONE: done=1 for exactly one cycle, then → IDLE.
  - start outside IDLE is ignored.
- busy=1 in RUN and DONE.
- Accept side:
  - rdy_out = (state==RUN) && !fifo_full && (row_in < NUM_ROWS).
  - Push on vld_in && rdy_out, then row_in++.
  - rdy_out is registered-independent of sram_rdy (no combinational path from sram_rdy).
  - vld_in while rdy_out=0 is held by upstream and is not lost.
- FIFO: 2 entries of EMB_DIM*ELEM_W, registered. Push and pop in the same cycle are legal when not full. No bypass: a vector pushed in cycle N produces its first sram_we in cycle N+1 at earliest.
- Write side:
  - sram_we=1 whenever the FIFO is non-empty in RUN.
  - sram_wdata = head elements [beat*ELEMS_PER_WORD .. +ELEMS_PER_WORD-1]; the lowest element goes in the LSBs.
  - sram_addr = base + row_out*WPV + beat, computed modulo 2^ADDR_W (wrap permitted, no error).
  - While sram_we=1 && sram_rdy=0, addr and data stay stable.
  - On acceptance: beat++. If beat==WPV-1 then beat=0, pop head, row_out++.
- Throughput: one vector per WPV cycles with sram_rdy held at 1. Upstream stalls only when both entries are occupied.
- Simultaneous events: a push on the same cycle as the last-beat pop of a full FIFO is not allowed, because rdy_out is low when full. A start pulse coincident with DONE is ignored.

Decomposition:
- Shared package holds:
  - O_VECTOR_T and the element width.
  - OSRAM word type and ADDR_W.
  - `MAX_EMBEDDING_DIM`.
  - A WPV constant.
- Natural sub-module: `vec_fifo2`, a 2-entry parameterized-width register FIFO with push/pop/full/empty.
- FSM, counters and beat mux live in `o_writeback`.

Test Plan:
1. Reset then start with base=0x100; push one vector with element i = i, sram_rdy=1 → sram_we for cycles 1..8. Addresses 0x100..0x107. Word 0 = elements 0..7 (LSB first), word 7 = elements 56..63.
2. NUM_ROWS=4, vld_in held high, sram_rdy=1 → 32 writes at base..base+31. rdy_out drops when the FIFO holds 2 vectors. done is one pulse one cycle after the 32nd acceptance. busy falls with DONE exit.
3. sram_rdy toggling 1,0,0,1,… during a vector → addr and data hold through the stalls; no beat is skipped or duplicated; total accepted beats = 8.
4. base=0xFFC, ADDR_W=12 → addresses 0xFFC,0xFFD,0xFFE,0xFFF,0x000..0x003.
5. Assert rst low mid-vector (beat 3) → next cycle sram_we=0, rdy_out=0, busy=0. A new start writes from the new base with beat 0.
6. start pulsed during RUN with a different base → ignored; addresses continue from the original base.

Source files
------------

// File: rtl/o_writeback_pkg.sv
// Shared types and constants for the output writeback path between the PE backend
// and the OSRAM write port.
package o_writeback_pkg;

  localparam int unsigned MaxEmbeddingDim = 64;
  localparam int unsigned ElemW           = 16;
  localparam int unsigned ElemsPerWord    = 8;
  localparam int unsigned AddrW           = 12;
  localparam int unsigned Wpv             = MaxEmbeddingDim / ElemsPerWord;

  typedef logic [ElemW-1:0]                 o_elem_t;
  typedef logic [MaxEmbeddingDim*ElemW-1:0] o_vector_t;
  typedef logic [ElemsPerWord*ElemW-1:0]    osram_word_t;
  typedef logic [AddrW-1:0]                 osram_addr_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } wb_state_e;

  // Counter width that stays legal when the range collapses to a single value.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/o_writeback_fifo.sv
// Two-entry register FIFO (vec_fifo2) holding whole output vectors. Push is ignored
// when full and pop when empty; simultaneous push and pop is allowed when not full.
module vec_fifo2 #(
  parameter int unsigned Width = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  always_comb begin
    full_o  = (cnt_q == 2'd2);
    empty_o = (cnt_q == 2'd0);
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && !empty_o;
    rdata_o = mem_q[rd_ptr_q];
    cnt_d   = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/o_writeback.sv
// Buffers up to two scaled PE output vectors and serialises each into consecutive
// OSRAM write beats; pulses done after NUM_ROWS vectors have been fully written.
module o_writeback
  import o_writeback_pkg::*;
#(
  parameter int unsigned EMB_DIM        = MaxEmbeddingDim,
  parameter int unsigned ELEM_W         = ElemW,
  parameter int unsigned ELEMS_PER_WORD = ElemsPerWord,
  parameter int unsigned NUM_ROWS       = 128,
  parameter int unsigned ADDR_W         = AddrW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                base_addr_in,
  input  logic                             vld_in,
  output logic                             rdy_out,
  input  logic [EMB_DIM*ELEM_W-1:0]        o_vec_in,
  output logic                             sram_we,
  input  logic                             sram_rdy,
  output logic [ADDR_W-1:0]                sram_addr,
  output logic [ELEMS_PER_WORD*ELEM_W-1:0] sram_wdata,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned WPV   = EMB_DIM / ELEMS_PER_WORD;
  localparam int unsigned VecW  = EMB_DIM * ELEM_W;
  localparam int unsigned WordW = ELEMS_PER_WORD * ELEM_W;
  localparam int unsigned BeatW = clog2_min1(WPV);
  localparam int unsigned RowW  = $clog2(NUM_ROWS + 1);

  wb_state_e         state_q, state_d;
  logic [RowW-1:0]   row_in_q, row_in_d;
  logic [RowW-1:0]   row_out_q, row_out_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [VecW-1:0] fifo_head;
  logic            accept, last_beat;

  vec_fifo2 #(
    .Width(VecW)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .wdata_i(o_vec_in),
    .rdata_o(fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      row_in_q  <= '0;
      row_out_q <= '0;
      beat_q    <= '0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_in_q  <= row_in_d;
      row_out_q <= row_out_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_in_d  = row_in_q;
    row_out_d = row_out_q;
    beat_d    = beat_q;
    base_d    = base_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          row_in_d  = '0;
          row_out_d = '0;
          beat_d    = '0;
          base_d    = base_addr_in;
        end
      end
      StRun: begin
        if (fifo_push) begin
          row_in_d = row_in_q + RowW'(1);
        end
        if (accept) begin
          if (last_beat) begin
            beat_d    = '0;
            row_out_d = row_out_q + RowW'(1);
            if (row_out_q == RowW'(NUM_ROWS - 1)) begin
              state_d = StDone;
            end
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // rdy_out depends only on registered state, never on sram_rdy.
  always_comb begin
    rdy_out    = (state_q == StRun) && !fifo_full && (row_in_q < RowW'(NUM_ROWS));
    sram_we    = (state_q == StRun) && !fifo_empty;
    accept     = sram_we && sram_rdy;
    last_beat  = (beat_q == BeatW'(WPV - 1));
    fifo_push  = vld_in && rdy_out;
    fifo_pop   = accept && last_beat;
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    sram_addr  = base_q + ADDR_W'(row_out_q) * ADDR_W'(WPV) + ADDR_W'(beat_q);
    sram_wdata = sram_we ? fifo_head[WordW*beat_q +: WordW] : '0;
  end

endmodule
